// File: rtl/descale_pkg.sv
// Shared constants and types for the descale_by_n accumulator descaler.
// The optional rounding stage is enabled by defining DESCALE_ROUND_EN.
package descale_pkg;

  localparam int N_DEF  = 8;
  localparam int W_DEF  = 20;
  localparam int SW_DEF = 5;
  localparam int CW_DEF = 16;

  // Stage-1 intermediate: the accumulator sign-extended by one bit so the
  // rounding bias can never overflow.
  typedef logic signed [W_DEF:0] stage1_t;

  function automatic int SAT_MAX(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  function automatic int SAT_MIN(input int n);
    return -(1 << (n - 1));
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational clamp of a (W+1)-bit signed value to the N-bit signed range,
// flagging when the value had to be clamped.
module sat_clamp
  import descale_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic signed [W:0]   value,
  output logic signed [N-1:0] result,
  output logic                sat
);

  localparam logic signed [W:0]   HI     = (W+1)'(SAT_MAX(N));
  localparam logic signed [W:0]   LO     = (W+1)'(SAT_MIN(N));
  localparam logic signed [N-1:0] HI_OUT = N'(SAT_MAX(N));
  localparam logic signed [N-1:0] LO_OUT = N'(SAT_MIN(N));

  always_comb begin
    result = value[N-1:0];
    sat    = 1'b0;
    if (value > HI) begin
      result = HI_OUT;
      sat    = 1'b1;
    end else if (value < LO) begin
      result = LO_OUT;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/descale_by_n.sv
// Two-stage descaler: arithmetic right shift (optionally rounded when
// DESCALE_ROUND_EN is defined), then saturation to N bits with a sat counter.
module descale_by_n
  import descale_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  input  logic [SW-1:0]       in_shift,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_data,
  output logic                out_sat,
  output logic [CW-1:0]       sat_count
);

  // Handshake: a beat moves on a rising edge when valid && ready on that side;
  // valid never depends on ready, and a presented output stays unchanged
  // until it is taken.
  logic                s1_valid;
  logic signed [W:0]   s1_data;
  logic                adv1, adv2;
  logic [SW-1:0]       s_eff;
  logic signed [W:0]   ext, biased, shifted;
  logic signed [N-1:0] clamp_data;
  logic                clamp_sat;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && !rst;

  always_comb begin
    s_eff = in_shift;
    if (int'(in_shift) > W) s_eff = SW'(W);
    ext    = {in_data[W-1], in_data};
    biased = ext;
`ifdef DESCALE_ROUND_EN
    // Half-LSB bias gives round-half-up once the shift truncates toward -inf.
    if (s_eff != '0) biased = ext + ((W+1)'(1) << (s_eff - 1'b1));
`endif
    shifted = biased >>> s_eff;
  end

  sat_clamp #(.N(N), .W(W)) u_sat_clamp (
    .value  (s1_data),
    .result (clamp_data),
    .sat    (clamp_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      sat_count <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) s1_data <= shifted;
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= clamp_data;
          out_sat  <= clamp_sat;
        end
      end
      if (out_valid && out_ready && out_sat && sat_count != {CW{1'b1}})
        sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_descale_by_n.sv
// Scoreboard bench for descale_by_n: drivers push model results into exp_q,
// a negedge monitor pops and compares every delivered beat.
module tb_descale_by_n;
  import descale_pkg::*;

  localparam int N  = 8;
  localparam int W  = 20;
  localparam int SW = 5;
  localparam int CW = 3;   // small counter so the sticky limit is reachable

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_data = '0;
  logic [SW-1:0]       in_shift = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [N-1:0] out_data;
  logic                out_sat;
  logic [CW-1:0]       sat_count;

  logic [N:0] exp_q[$];
  int         sc_model = 0;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         accepted = 0;
  int         cyc = 0;
  int         in_xfer_cyc = 0;
  int         out_xfer_cyc = 0;
  bit         stalled = 0;
  logic [N:0] held = '0;
  bit         rand_ready_en = 0;
  bit         bp_done = 0;

  descale_by_n #(.N(N), .W(W), .SW(SW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_count (sat_count)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: floor(x / 2^s) (with +2^(s-1) bias when rounding), then clamp.
  function automatic logic [N:0] model(input longint x, input int sh);
    longint s, d, v, q, hi, lo;
    s  = (sh > W) ? W : sh;
    d  = longint'(1) << s;
    v  = x;
`ifdef DESCALE_ROUND_EN
    if (s > 0) v = v + d / 2;
`endif
    q  = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    hi = (longint'(1) << (N - 1)) - 1;
    lo = -(longint'(1) << (N - 1));
    if (q > hi) return {1'b1, hi[N-1:0]};
    if (q < lo) return {1'b1, lo[N-1:0]};
    return {1'b0, q[N-1:0]};
  endfunction

  // driver tasks (called at posedge+1, return at posedge+1 after the transfer)
  task automatic send(input logic signed [W-1:0] d, input logic [SW-1:0] sh);
    in_valid = 1'b1;
    in_data  = d;
    in_shift = sh;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(longint'(d), int'(sh)));
        accepted++;
        in_xfer_cyc = cyc;
        @(posedge clk);
        #1;
        return;
      end
    end
    check("in_ready_timeout", longint'(in_ready), 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [N:0] e;
    if (rst) begin
      stalled = 0;
    end else begin
      check("sat_count", longint'(sat_count), sc_model);
      if (stalled) begin
        check("stall_valid_held", longint'(out_valid), 1);
        check("stall_data_held", longint'({out_sat, out_data}), longint'(held));
      end
      stalled = out_valid && !out_ready;
      held    = {out_sat, out_data};
      if (out_valid && out_ready) begin
        out_xfer_cyc = cyc;
        check("beat_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", longint'(out_data), longint'($signed(e[N-1:0])));
          check("out_sat", longint'(out_sat), longint'(e[N]));
          if (e[N] && sc_model < (1 << CW) - 1) sc_model++;
        end
      end
    end
  end

  // random backpressure during the random phase
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic signed [W-1:0] rd;
    logic [31:0]         r;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    check("rst_sat_count", longint'(sat_count), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // pass-through, latency, rounding, saturation, large shift
    out_ready = 1'b1;
    send(256, 2);
    idle(4);
    check("latency", out_xfer_cyc - in_xfer_cyc, 2);
    send(5, 1);
    send(-3, 1);
    send(100000, 4);
    send(-100000, 0);
    send(-1, 31);
    send(0, 0);
    send(-4, 20);
    send(12, 20);
    idle(4);
    drain();

    // backpressure: 4 beats offered while output is stalled
    out_ready = 1'b0;
    accepted  = 0;
    bp_done   = 0;
    fork
      begin
        send(11, 0);
        send(-22, 0);
        send(300, 1);
        send(-77, 0);
        in_valid = 1'b0;
        bp_done  = 1;
      end
    join_none
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_accepted", accepted, 2);
    check("bp_in_ready_low", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_comb", longint'(in_ready), 1);
    for (int i = 0; i < 100 && !bp_done; i++) @(posedge clk);
    check("bp_all_sent", longint'(bp_done), 1);
    drain();
    check("bp_accepted_total", accepted, 4);

    // reset with two beats in flight
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(1000, 0);
    send(7, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    sc_model = 0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_sat_count", longint'(sat_count), 0);
    check("midrst_in_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_release", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(6);

    // randomized traffic with random backpressure
    rand_ready_en = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      case (r[1:0])
        2'd0:    rd = W'($urandom_range(0, 400)) - W'(200);
        2'd1:    rd = W'($urandom_range(0, 4000)) - W'(2000);
        default: rd = W'($urandom);
      endcase
      send(rd, SW'($urandom_range(0, 31)));
      if (r[4:2] == 3'd0) idle($urandom_range(1, 3));
    end
    in_valid = 1'b0;
    rand_ready_en = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    idle(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/descale_by_n.md
# descale_by_n

Pipelined arithmetic descaler that is the inverse of the shift-left multiply-by-2^S path in the MACC datapath. It takes a wide signed accumulator value and divides it by 2^shift via an arithmetic right shift, with optional round-to-nearest. It then saturates the result back to the N-bit activation width. The block sits between the MACC accumulator and the activation write-back path. Valid/ready handshakes sit on both sides, and a running count of saturation events is kept.

## Interface
- N, 8, output (activation) width, signed
- W, 20, input (accumulator) width, signed
- SW, 5, width of the runtime shift amount
- CW, 16, width of the saturation event counter

One clock; reset is synchronous and active-high.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  W  signed accumulator value
- in_shift  in  SW  right-shift amount (divide by 2^in_shift)
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the beat this cycle
- out_data  out  N  signed descaled, saturated result
- out_sat  out  1  out_data was clamped
- sat_count  out  CW  number of saturated beats delivered, sticks at all-ones

## Operation
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready on a rising edge.
- Effective shift: s = min(in_shift, W).
- Stage 1 (shift) performs the following, in order:
  - sign-extend in_data to W+1 bits;
  - with rounding, add 2^(s-1) when s>0 (nothing is added when s=0);
  - arithmetic right shift by s;
  - register the result with s1_valid.
- Stage 2 (saturate) compares the W+1-bit value with [-2^(N-1), 2^(N-1)-1]:
  - above the range: result 2^(N-1)-1, sat=1;
  - below the range: result -2^(N-1), sat=1;
  - otherwise: the low N bits, sat=0.
  - Result and flag are registered into out_data, out_sat and out_valid.
- Stage advance:
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 && !rst
- Bubbles collapse, so the block sustains full throughput with out_ready held high.
- sat_count increments by 1 on each output transfer with out_sat=1. It holds at 2^CW-1 and never wraps.
- Stalled outputs are held: out_data and out_sat stay stable while out_valid && !out_ready.
- Shift 0 passes the value through to saturation unchanged.
- Shifts ≥ W produce the sign (0 or -1) when truncating. When rounding, the result is 0 for any input with |x| < 2^(W-1).

## Timing
- Latency: 2 cycles from input transfer to out_valid, with no backpressure.
- Throughput: 1 beat/cycle.
- Capacity: 2 beats in flight (s1, out). With out_ready low, in_ready falls after 2 accepted beats, is combinational from out_ready, and returns in the same cycle out_ready rises.
- Reset values:
  - out_valid=0, s1_valid=0;
  - out_data=0, out_sat=0;
  - sat_count=0;
  - in_ready=0 while rst=1, and 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight beats. No beat is emitted for them.
- Simultaneous input transfer and output transfer in the same cycle is legal. Order is preserved.

## Configuration
- DESCALE_ROUND_EN defined: round half toward +inf (add 2^(s-1) before shift).
- Not defined: truncate toward -inf (plain arithmetic shift), with no adder in stage 1.

## Structure
- The shared package descale_pkg holds:
  - default N/W/SW/CW localparams;
  - the SAT_MAX/SAT_MIN constant functions of N;
  - the typedef for the stage-1 (W+1-bit) intermediate.
- One combinational sub-module, sat_clamp (W+1 in → N out plus sat flag), is instantiated in stage 2. Everything else stays in descale_by_n.

## Test plan
- Pass-through and latency: in_data=256, shift=2, out_ready=1 → out_data=64, out_sat=0, out_valid exactly 2 cycles after the transfer.
- Rounding:
  - in_data=5, shift=1 → 3 with DESCALE_ROUND_EN, 2 without;
  - in_data=-3, shift=1 → -1 with the macro, -2 without.
- Saturation and counter: in_data=100000, shift=4 → 127, out_sat=1; then in_data=-100000, shift=0 → -128, out_sat=1; sat_count=2.
- Large shift: in_data=-1, shift=31 → 0 with rounding, -1 without; out_sat=0.
- Backpressure: 4 beats offered back-to-back with out_ready=0 for 5 cycles. Expect in_ready=0 after 2 beats accepted, out_data stable, and all 4 delivered in order once out_ready=1 with no loss or duplication.
- Reset mid-stream: assert rst with 2 beats in flight → out_valid=0, sat_count=0 the next cycle. No stale beat appears after release, and in_ready=1 one cycle after rst drops.
